// File: rtl/roi_pkg.sv
// Shared types for the ROI stream gate.
// Border overlay in MASK mode is enabled with ROI_BORDER_EN.
package roi_pkg;

  localparam int PIX_BITS = 24;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic {
    MODE_CROP,
    MODE_MASK
  } mode_t;

endpackage

// File: rtl/roi_coord_counter.sv
// Raster x/y counter for the ROI gate.
// Advances one pixel per pop and wraps after the last pixel of the frame.
module roi_coord_counter
  import roi_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int X_BITS = 11,
  parameter int Y_BITS = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              last_pixel
);

  logic row_end;

  assign row_end    = (x == X_BITS'(WIDTH - 1));
  assign last_pixel = row_end && (y == Y_BITS'(HEIGHT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_pixel) begin
        x <= '0;
        y <= '0;
      end else if (row_end) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/roi_stream_gate.sv
// Runtime-configurable ROI crop/mask gate between two FWFT FIFOs.
// Define ROI_BORDER_EN to paint the ROI perimeter with BORDER_COLOR in MASK mode.
module roi_stream_gate
  import roi_pkg::*;
#(
  parameter int WIDTH    = 1280,
  parameter int HEIGHT   = 720,
  parameter int CHANNELS = 3,
  parameter int CH_BITS  = 8,
  parameter int X_BITS   = 11,
  parameter int Y_BITS   = 10
`ifdef ROI_BORDER_EN
  , parameter logic [CHANNELS*CH_BITS-1:0] BORDER_COLOR = 24'hFF0000
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        mode,
  input  logic [X_BITS-1:0]           roi_x0,
  input  logic [Y_BITS-1:0]           roi_y0,
  input  logic [X_BITS:0]             roi_w,
  input  logic [Y_BITS:0]             roi_h,
  input  logic [CHANNELS*CH_BITS-1:0] fill_color,
  input  logic [CHANNELS*CH_BITS-1:0] in_dout,
  input  logic                        in_empty,
  output logic                        in_rd_en,
  output logic [CHANNELS*CH_BITS-1:0] out_din,
  input  logic                        out_full,
  output logic                        out_wr_en,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int P = CHANNELS * CH_BITS;
  localparam logic [X_BITS+1:0] XLIM = (X_BITS+2)'(WIDTH);
  localparam logic [Y_BITS+1:0] YLIM = (Y_BITS+2)'(HEIGHT);

  state_t            state;
  mode_t             mode_q;
  logic [X_BITS+1:0] xs_q, xe_q, xe_sum, xe_new;
  logic [Y_BITS+1:0] ys_q, ye_q, ye_sum, ye_new;
  logic [P-1:0]      fill_q, pix;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic [X_BITS+1:0] xw;
  logic [Y_BITS+1:0] yw;
  logic              last_pixel, launch, run, in_roi;

  assign launch = (state == S_IDLE) && start;
  assign busy   = (state == S_RUN);
  assign run    = busy && !in_empty;

  // End bounds clipped to the frame; an out-of-frame origin yields an empty ROI
  assign xe_sum = (X_BITS+2)'(roi_x0) + (X_BITS+2)'(roi_w);
  assign ye_sum = (Y_BITS+2)'(roi_y0) + (Y_BITS+2)'(roi_h);
  assign xe_new = (xe_sum > XLIM) ? XLIM : xe_sum;
  assign ye_new = (ye_sum > YLIM) ? YLIM : ye_sum;

  assign xw     = (X_BITS+2)'(x);
  assign yw     = (Y_BITS+2)'(y);
  assign in_roi = (xw >= xs_q) && (xw < xe_q) &&
                  (yw >= ys_q) && (yw < ye_q);

  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    if (run) begin
      if (mode_q == MODE_CROP && !in_roi) begin
        in_rd_en = 1'b1;
      end else begin
        in_rd_en  = !out_full;
        out_wr_en = !out_full;
      end
    end
  end

  always_comb begin
    pix = in_dout;
    if (mode_q == MODE_MASK) begin
      if (!in_roi) begin
        pix = fill_q;
      end
`ifdef ROI_BORDER_EN
      else if (xw == xs_q || xw == xe_q - 1'b1 ||
               yw == ys_q || yw == ye_q - 1'b1) begin
        pix = BORDER_COLOR;
      end
`endif
    end
  end

  assign out_din = out_wr_en ? pix : '0;

  roi_coord_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_coord (
    .clock      (clock),
    .reset      (reset),
    .clear      (launch),
    .advance    (in_rd_en),
    .x          (x),
    .y          (y),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_rd_en && last_pixel;
      case (state)
        S_IDLE: if (start) state <= S_RUN;
        S_RUN:  if (in_rd_en && last_pixel) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_CROP;
      xs_q   <= '0;
      ys_q   <= '0;
      xe_q   <= '0;
      ye_q   <= '0;
      fill_q <= '0;
    end else if (launch) begin
      mode_q <= mode_t'(mode);
      xs_q   <= (X_BITS+2)'(roi_x0);
      ys_q   <= (Y_BITS+2)'(roi_y0);
      xe_q   <= xe_new;
      ye_q   <= ye_new;
      fill_q <= fill_color;
    end
  end

endmodule

// File: tb/tb_roi_stream_gate.sv
// Randomised self-checking bench for roi_stream_gate on an 8x4 frame.
// Reference model works directly from pixel index, ROI rectangle and mode.
module tb_roi_stream_gate;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int XB = 4;
  localparam int YB = 3;
  localparam int N  = W * H;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [XB-1:0] roi_x0;
  logic [YB-1:0] roi_y0;
  logic [XB:0]   roi_w;
  logic [YB:0]   roi_h;
  logic [23:0]   fill_color;
  logic [23:0]   in_dout;
  logic          in_empty;
  logic          in_rd_en;
  logic [23:0]   out_din;
  logic          out_full;
  logic          out_wr_en;
  logic          busy;
  logic          frame_done;

  int tests = 0;
  int fails = 0;
  int pushes;

  always #5 clock = ~clock;

  roi_stream_gate #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .CHANNELS (3),
    .CH_BITS  (8),
    .X_BITS   (XB),
    .Y_BITS   (YB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .roi_x0     (roi_x0),
    .roi_y0     (roi_y0),
    .roi_w      (roi_w),
    .roi_h      (roi_h),
    .fill_color (fill_color),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .out_din    (out_din),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit inside_roi(int idx, int x0, int y0, int w, int h);
    int x, y, xe, ye;
    x  = idx % W;
    y  = idx / W;
    xe = (x0 + w > W) ? W : x0 + w;
    ye = (y0 + h > H) ? H : y0 + h;
    return x >= x0 && x < xe && y >= y0 && y < ye;
  endfunction

  function automatic bit on_border(int idx, int x0, int y0, int w, int h);
    int x, y, xe, ye;
    x  = idx % W;
    y  = idx / W;
    xe = (x0 + w > W) ? W : x0 + w;
    ye = (y0 + h > H) ? H : y0 + h;
    return x == x0 || x == xe - 1 || y == y0 || y == ye - 1;
  endfunction

  // Runs one frame; abort_at>0 resets the DUT after that many pops.
  task automatic run_frame(input bit m, input int x0, input int y0,
                           input int w, input int h, input logic [23:0] fill,
                           input bit rnd, input int erate, input int frate,
                           input int fa, input int fb, input int abort_at,
                           output int npush);
    logic [23:0] src[N];
    logic [23:0] expq[$];
    int ptr, cyc;
    bit last_pop, ir, ep, ew;
    for (int i = 0; i < N; i++) begin
      src[i] = rnd ? 24'($urandom) : 24'(i);
      if (inside_roi(i, x0, y0, w, h)) begin
`ifdef ROI_BORDER_EN
        if (m && on_border(i, x0, y0, w, h)) expq.push_back(24'hFF0000);
        else expq.push_back(src[i]);
`else
        expq.push_back(src[i]);
`endif
      end else if (m) begin
        expq.push_back(fill);
      end
    end
    @(posedge clock); #1;
    mode = m; roi_x0 = XB'(x0); roi_y0 = YB'(y0);
    roi_w = (XB+1)'(w); roi_h = (YB+1)'(h); fill_color = fill;
    in_empty = 1'b1; out_full = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    roi_x0 = XB'($urandom); roi_w = (XB+1)'($urandom);
    fill_color = 24'($urandom); mode = ~m;
    ptr = 0; cyc = 0; last_pop = 0; npush = 0;
    while (cyc < 2000) begin
      in_dout  = (ptr < N) ? src[ptr] : 24'h0;
      in_empty = (ptr >= N) || ($urandom_range(99) < erate);
      out_full = ($urandom_range(99) < frate) || (cyc >= fa && cyc <= fb);
      @(negedge clock);
      chk("frame_done", frame_done, last_pop);
      if (last_pop) begin
        chk("busy_after", busy, 0);
        break;
      end
      chk("busy", busy, 1);
      ir = inside_roi(ptr, x0, y0, w, h);
      ep = !in_empty && (!out_full || (!m && !ir));
      ew = !in_empty && !out_full && (m || ir);
      chk("in_rd_en", in_rd_en, ep);
      chk("out_wr_en", out_wr_en, ew);
      if (out_wr_en) begin
        npush++;
        if (expq.size() == 0) chk("extra_push", 1, 0);
        else chk("out_din", out_din, expq.pop_front());
      end
      if (in_rd_en) begin
        ptr++;
        last_pop = (ptr == N);
      end
      if (abort_at > 0 && ptr == abort_at) begin
        reset = 1'b0; #1;
        chk("abort_rd", in_rd_en, 0);
        chk("abort_wr", out_wr_en, 0);
        chk("abort_din", out_din, 0);
        chk("abort_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          chk("abort_no_done", frame_done, 0);
        end
        return;
      end
      @(posedge clock); #1;
      cyc++;
    end
    if (cyc >= 2000) chk("timeout", cyc, 0);
    chk("pops", ptr, N);
    chk("leftover", expq.size(), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    roi_x0 = '0; roi_y0 = '0; roi_w = '0; roi_h = '0;
    fill_color = 24'h123456; in_dout = 24'hABCDEF;
    in_empty = 1'b0; out_full = 1'b0;
    #3;
    chk("rst_rd", in_rd_en, 0);
    chk("rst_wr", out_wr_en, 0);
    chk("rst_din", out_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("idle_rd", in_rd_en, 0);

    run_frame(0, 2, 1, 3, 2, 24'h0, 0, 0, 0, -1, -1, 0, pushes);
    chk("crop_count", pushes, 6);
    run_frame(1, 2, 1, 3, 2, 24'h00FF00, 0, 0, 0, -1, -1, 0, pushes);
    chk("mask_count", pushes, 32);
    run_frame(0, 2, 1, 3, 2, 24'h0, 0, 0, 0, 5, 9, 0, pushes);
    chk("stall_count", pushes, 6);
    run_frame(0, 6, 0, 5, 1, 24'h0, 0, 0, 0, -1, -1, 0, pushes);
    chk("clip_count", pushes, 2);
    run_frame(0, 2, 1, 3, 2, 24'h0, 0, 0, 0, -1, -1, 12, pushes);
    run_frame(0, 2, 1, 3, 2, 24'h0, 0, 0, 0, -1, -1, 0, pushes);
    chk("post_abort_count", pushes, 6);
    run_frame(1, 1, 1, 4, 3, 24'h0000FF, 0, 0, 0, -1, -1, 0, pushes);
    run_frame(0, 0, 0, 0, 4, 24'h0, 1, 20, 20, -1, -1, 0, pushes);
    chk("empty_w_count", pushes, 0);
    run_frame(1, 9, 0, 3, 2, 24'h777777, 1, 20, 20, -1, -1, 0, pushes);
    chk("oob_mask_count", pushes, 32);
    for (int f = 0; f < 8; f++) begin
      run_frame(1'($urandom), $urandom_range(9), $urandom_range(4),
                $urandom_range(10), $urandom_range(5), 24'($urandom),
                1, 30, 30, -1, -1, 0, pushes);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/roi_stream_gate.md
Name: roi_stream_gate

Overview:
Streaming region-of-interest gate between the full-frame pixel input FIFO and the lane-detection pipeline input FIFO. Tracks raster (x,y) of each input pixel. Each frame runs in one of two modes:
- CROP: forwards only pixels inside a runtime-configured rectangle.
- MASK: forwards every pixel, replacing out-of-ROI pixels with a fill colour.
It replaces fixed-size crop logic with a parametrised, runtime-configurable block for any frame size and channel count.

Parameters:
WIDTH, 1280, frame width in pixels
HEIGHT, 720, frame height in pixels
CHANNELS, 3, colour channels per pixel
CH_BITS, 8, bits per channel
X_BITS, 11, coordinate width for x (>= clog2(WIDTH))
Y_BITS, 10, coordinate width for y (>= clog2(HEIGHT))
BORDER_COLOR, 24'hFF0000, perimeter colour used only with ROI_BORDER_EN (width CHANNELS*CH_BITS)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches config, begins frame
mode  in  1  0=CROP, 1=MASK (latched at start)
roi_x0  in  X_BITS  ROI left column
roi_y0  in  Y_BITS  ROI top row
roi_w  in  X_BITS+1  ROI width in pixels
roi_h  in  Y_BITS+1  ROI height in pixels
fill_color  in  CHANNELS*CH_BITS  out-of-ROI replacement value (MASK)
in_dout  in  CHANNELS*CH_BITS  first-word-fall-through input data
in_empty  in  1  input FIFO empty
in_rd_en  out  1  input FIFO pop
out_din  out  CHANNELS*CH_BITS  output FIFO data
out_full  in  1  output FIFO full
out_wr_en  out  1  output FIFO push
busy  out  1  high in RUN
frame_done  out  1  one-cycle pulse after last pixel consumed

Behaviour:
- Reset (reset=0, async): state IDLE; x=y=0; busy=0; frame_done=0. in_rd_en, out_wr_en and out_din are combinational and evaluate to 0.
- States: IDLE -> RUN on start. RUN -> IDLE after the pixel at (WIDTH-1, HEIGHT-1) is consumed; frame_done pulses high the following cycle. start is ignored in RUN.
- Config latch: at start, latch all config inputs.
  - Effective ROI: x in [roi_x0, min(roi_x0+roi_w, WIDTH)), same rule for y.
  - roi_w=0 or roi_h=0, or x0 >= WIDTH / y0 >= HEIGHT: empty ROI. CROP emits nothing; MASK emits all fill.
- in_roi is combinational from the current x,y.
- Per cycle in RUN, with in_empty=0:
  - CROP, in_roi=1: in_rd_en = out_wr_en = !out_full; out_din = in_dout.
  - CROP, in_roi=0: in_rd_en=1, out_wr_en=0 (drop; not gated by out_full).
  - MASK: in_rd_en = out_wr_en = !out_full; out_din = in_roi ? in_dout : fill_color.
- Latency: zero cycles; the push occurs in the same cycle as the pop.
- With in_empty=1: no pop, no push, coordinates hold.
- Coordinate advance only on in_rd_en:
  - x==WIDTH-1: x=0, y++.
  - Otherwise x++.
  - Wrap at (WIDTH-1, HEIGHT-1) resets x=y=0.
- Simultaneous out_full and in-ROI pixel: stall; no data loss, no duplication.
- Reset mid-frame: abort immediately; no frame_done; the next start begins at (0,0).
- Arithmetic: ROI end bounds computed at X_BITS+2 / Y_BITS+2 width to avoid overflow.

Optional Feature:
Macro ROI_BORDER_EN.
- Defined: in MASK mode, in-ROI pixels with x==x_start, x==x_end-1, y==y_start or y==y_end-1 output BORDER_COLOR instead of in_dout. CROP mode is unaffected.
- Undefined: no border logic; perimeter pixels pass in_dout unchanged.

Decomposition:
- Package roi_pkg:
  - state enum (S_IDLE, S_RUN)
  - mode enum (MODE_CROP, MODE_MASK)
  - PIX_BITS = CHANNELS*CH_BITS default constant
- Sub-module roi_coord_counter: x/y raster counter with advance enable, wrap, and last_pixel flag; instantiated once.

Test Plan:
- Bench parameters WIDTH=8, HEIGHT=4, CROP, ROI (2,1,3,2), input values 0..31 -> out sequence 10,11,12,18,19,20; exactly 32 pops; frame_done one cycle after pop 32.
- MASK, same ROI, fill_color=24'h00FF00 -> 32 writes; index 10 = 10; index 0 and index 31 = 24'h00FF00.
- out_full held high for cycles 5-9 during the CROP run -> no pop of in-ROI pixels while full; output sequence identical to scenario 1.
- roi_x0=6, roi_w=5 (clipped), roi_y0=0, roi_h=1, CROP -> outputs 6,7 only.
- reset asserted after 12 pops, then start with the same config -> frame_done never pulses for the aborted frame; the second frame matches scenario 1.
- ROI_BORDER_EN defined, MASK, ROI (1,1,4,3), BORDER_COLOR=24'hFF0000 -> pixels 9,10,11,12 and 25..28 = FF0000; 17 and 20 = FF0000; 18,19 pass through.
